// File: rtl/hazard_fw_unit_if.sv
// Hazard/forwarding control bundle between the pipeline datapath and hazard_fw_unit.
// master drives pipeline state; slave (the unit) returns selects and stall controls.
interface hazard_fw_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
    logic [5*NUM_SRC-1:0]     ifid_rs;
    logic [NUM_SRC-1:0]       ifid_rs_used;
    logic [5*NUM_SRC-1:0]     idex_rs;
    logic [4:0]               idex_rd;
    logic                     idex_load_regfile;
    logic                     idex_is_load;
    logic [5*NUM_FWD-1:0]     fwd_rd;
    logic [NUM_FWD-1:0]       fwd_load_regfile;
    logic [NUM_FWD-1:0]       fwd_is_load;
    logic                     mem_stall;
    logic [SEL_W*NUM_SRC-1:0] fwd_sel;
    logic                     stall_pc;
    logic                     stall_ifid;
    logic                     bubble_idex;
    logic                     stall_all;
    logic [CNT_W-1:0]         bubble_count;

    modport master (
        output ifid_rs, ifid_rs_used, idex_rs, idex_rd, idex_load_regfile, idex_is_load,
               fwd_rd, fwd_load_regfile, fwd_is_load, mem_stall,
        input  fwd_sel, stall_pc, stall_ifid, bubble_idex, stall_all, bubble_count
    );

    modport slave (
        input  ifid_rs, ifid_rs_used, idex_rs, idex_rd, idex_load_regfile, idex_is_load,
               fwd_rd, fwd_load_regfile, fwd_is_load, mem_stall,
        output fwd_sel, stall_pc, stall_ifid, bubble_idex, stall_all, bubble_count
    );
endinterface

// File: rtl/hazard_fw_unit.sv
// EX-stage forwarding select generation plus ID-stage load-use bubble FSM
// with a saturating bubble counter.
module hazard_fw_unit #(
    parameter int NUM_SRC      = 2,
    parameter int NUM_FWD      = 2,
    parameter int LOAD_USE_LAT = 1,
    parameter int CNT_W        = 16,
    parameter int SEL_W        = $clog2(NUM_FWD + 1)
) (
    input  logic           clk,
    input  logic           rst,
    hazard_fw_unit_if.slave bus
);
    localparam int CW = $clog2(LOAD_USE_LAT + 1);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CNT_W-1:0]     bcount;
    logic [NUM_SRC-1:0]   found;
    logic                 hazard;
    logic                 bubble;

    // First qualifying stage in youngest-to-oldest order wins; loads still too
    // young to have data are skipped so an older stage may supply the value.
    always_comb begin
        bus.fwd_sel = '0;
        found       = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                for (int unsigned k = 0; k < NUM_FWD; k++) begin
                    if (!found[i] && bus.fwd_load_regfile[k] &&
                        bus.fwd_rd[5*k +: 5] != 5'd0 &&
                        bus.fwd_rd[5*k +: 5] == bus.idex_rs[5*i +: 5] &&
                        !((k + 1 < LOAD_USE_LAT) && bus.fwd_is_load[k])) begin
                        found[i]                     = 1'b1;
                        bus.fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.ifid_rs_used[i] && bus.idex_is_load && bus.idex_load_regfile &&
                bus.idex_rd != 5'd0 && bus.ifid_rs[5*i +: 5] == bus.idex_rd)
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bubble        = 1'b0;
        bus.stall_all = 1'b0;
        if (rst) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            bus.stall_all = bus.mem_stall;
            if (!bus.mem_stall) begin
                case (state)
                    RUN: begin
                        if (hazard) begin
                            bubble = 1'b1;
                            if (LOAD_USE_LAT > 1) begin
                                state_nxt = BUBBLE;
                                cnt_nxt   = CW'(LOAD_USE_LAT - 1);
                            end
                        end
                    end
                    BUBBLE: begin
                        bubble  = 1'b1;
                        cnt_nxt = cnt - CW'(1);
                        if (cnt == CW'(1))
                            state_nxt = RUN;
                    end
                    default: state_nxt = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= '0;
            bcount <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (bubble && bcount != '1)
                bcount <= bcount + CNT_W'(1);
        end
    end

    assign bus.stall_pc     = bubble;
    assign bus.stall_ifid   = bubble;
    assign bus.bubble_idex  = bubble;
    assign bus.bubble_count = bcount;
endmodule
